// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_t    : operation encoding presented on the op port
//   muldiv_state_t : control FSM states
//   is_signed()    : operation treats its operands as two's complement
//   is_div()       : operation is a divide (DIV/DIVU)
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic is_signed(input muldiv_op_t op);
    logic r;
    case (op)
      OP_MULT: r = 1'b1;
      OP_DIV:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div(input muldiv_op_t op);
    logic r;
    case (op)
      OP_DIV:  r = 1'b1;
      OP_DIVU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath on a
// 2*WIDTH+1 accumulator.
//   Multiply (shift-add): acc = {carry, partial product, remaining multiplier}.
//     If the multiplier LSB is set, the multiplicand is added to the upper
//     half, then the whole accumulator shifts right by one.
//   Divide (restoring): acc = {remainder (W+1), dividend/quotient (W)}.
//     Shift left by one, trial-subtract the divisor, keep the difference and
//     shift in a 1 when it does not underflow, else keep the shifted value.
// Ports:
//   i_is_div  : 1 selects the divide step, 0 the multiply step
//   i_acc     : accumulator before the step
//   i_operand : multiplicand (multiply) or divisor (divide), magnitudes
//   o_acc     : accumulator after the step
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH:0]   o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_diff;

  // The top accumulator bit is always zero between steps: the remainder
  // stays below the divisor and the multiply carry is shifted down each step.
  logic w_unused_top;
  assign w_unused_top = i_acc[2*WIDTH];

  // Single multiply or divide iteration
  always_comb begin
    w_sum       = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
                  (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
    w_shift_rem = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_diff      = w_shift_rem - {1'b0, i_operand};
    o_acc       = {(2*WIDTH+1){1'b0}};
    if (i_is_div) begin
      if (w_shift_rem >= {1'b0, i_operand}) begin
        o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_shift_rem, i_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Serves MULT/MULTU/DIV/DIVU (start/busy/done handshake) and MTHI/MTLO
// (wr_hi/wr_lo). Signed operations run on magnitudes and are sign-corrected
// in a final FIX cycle. Divide by zero skips CALC and leaves HI/LO intact.
// Optional build macro:
//   MULDIV_EARLY_EXIT_EN : multiplies leave CALC as soon as the remaining
//                          multiplier is zero (min. one CALC cycle).
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   start, op           : request and operation, sampled only when accepted
//   src_a, src_b        : multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo, wr_data : direct HI/LO writes
//   busy, done, div_zero  : handshake and divide-by-zero pulse
//   hi, lo              : HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_t    r_state;
  muldiv_state_t    w_state_nxt;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_operand;
  logic [CW-1:0]    r_count;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] r_mplier;
`endif

  logic             w_accept;
  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_op_div;
  logic             w_dz_req;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_exit;
  logic [2*WIDTH:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  logic w_unused_acc_top;
  assign w_unused_acc_top = r_acc[2*WIDTH];

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (r_is_div),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_acc_step)
  );

  // Request decode: operand magnitudes and signs, acceptance, CALC exit
  always_comb begin
    // The done cycle is already IDLE, so a start there must be masked.
    w_accept = (r_state == ST_IDLE) && start && !r_done;
    w_sgn    = is_signed(op);
    w_op_div = is_div(op);
    w_a_neg  = w_sgn & src_a[WIDTH-1];
    w_b_neg  = w_sgn & src_b[WIDTH-1];
    w_abs_a  = w_a_neg ? (~src_a + WIDTH'(1)) : src_a;
    w_abs_b  = w_b_neg ? (~src_b + WIDTH'(1)) : src_b;
    w_dz_req = w_op_div && (src_b == {WIDTH{1'b0}});
`ifdef MULDIV_EARLY_EXIT_EN
    w_exit   = (r_count == CW'(1)) ||
               (!r_is_div && (r_mplier[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
`else
    w_exit   = (r_count == CW'(1));
`endif
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    // After an early exit the product still sits r_count places too high.
    w_prod = r_acc[2*WIDTH-1:0] >> r_count;
    if (r_neg_q) begin
      w_prod = ~w_prod + (2*WIDTH)'(1);
    end else begin
      w_prod = w_prod;
    end
    w_quot = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1))
                     : r_acc[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
    end else begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dz_req ? ST_FIX : ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (w_exit) begin
          w_state_nxt = ST_FIX;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, handshake outputs and HI/LO registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc      <= {(2*WIDTH+1){1'b0}};
      r_operand  <= {WIDTH{1'b0}};
      r_count    <= {CW{1'b0}};
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
      r_mplier   <= {WIDTH{1'b0}};
`endif
    end else begin
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;

      // FIX write-back takes priority over MTHI/MTLO on the same edge.
      if ((r_state == ST_FIX) && !r_dz) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else begin
        if (wr_hi) r_hi <= wr_data;
        if (wr_lo) r_lo <= wr_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc     <= {1'b0, {WIDTH{1'b0}}, (w_op_div ? w_abs_a : w_abs_b)};
            r_operand <= w_op_div ? w_abs_b : w_abs_a;
            r_count   <= CW'(WIDTH);
            r_is_div  <= w_op_div;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_dz      <= w_dz_req;
`ifdef MULDIV_EARLY_EXIT_EN
            r_mplier  <= w_abs_b;
`endif
          end
        end
        ST_CALC: begin
          r_acc   <= w_acc_step;
          r_count <= r_count - CW'(1);
`ifdef MULDIV_EARLY_EXIT_EN
          r_mplier <= r_mplier >> 1;
`endif
        end
        ST_FIX: begin
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  muldiv_op_t   op;
  logic [W-1:0] src_a, src_b, wr_data;
  logic         wr_hi, wr_lo;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Multiply latency in edges from the accepting edge to done.
  function automatic int mul_lat(input logic [W-1:0] b);
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return EE ? n + 1 : W + 1;
  endfunction

  // Issue a one-cycle start; returns at the negedge just after the accepting edge.
  task automatic launch(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Step negedges until done, bounded; counts samples where busy was low.
  task automatic wait_done(input int k0, output int k, output int gaps);
    k = k0; gaps = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy !== 1'b1) gaps++;
      @(negedge clock);
      k++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k, gaps, seen, kre, lat;
    reset = 1'b0; start = 1'b0; op = OP_MULT; src_a = 32'd0; src_b = 32'd0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1. MULT -3 * 7
    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    check("t1_busy_k0", {31'd0, busy}, 32'd1);
    wait_done(0, k, gaps);
    check("t1_lat", k, mul_lat(32'd7));
    check("t1_busy_gaps", gaps, 32'd0);
    check("t1_busy_at_done", {31'd0, busy}, 32'd0);
    check("t1_dz", {31'd0, div_zero}, 32'd0);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFEB);
    @(negedge clock);
    check("t1_done_pulse", {31'd0, done}, 32'd0);

    // 2. MULTU max*max, 0*0
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, k, gaps);
    check("t2_lat", k, mul_lat(32'hFFFF_FFFF));
    check("t2_hi", hi, 32'hFFFF_FFFE);
    check("t2_lo", lo, 32'h0000_0001);
    launch(OP_MULTU, 32'd0, 32'd0);
    wait_done(0, k, gaps);
    check("t2z_lat", k, mul_lat(32'd0));
    check("t2z_hi", hi, 32'd0);
    check("t2z_lo", lo, 32'd0);

    // 3. Divides
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, k, gaps);
    check("t3_lat", k, 32'd33);
    check("t3_lo", lo, 32'hFFFF_FFFD);
    check("t3_hi", hi, 32'hFFFF_FFFF);
    launch(OP_DIVU, 32'd7, 32'd2);
    wait_done(0, k, gaps);
    check("t3u_lo", lo, 32'd3);
    check("t3u_hi", hi, 32'd1);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, k, gaps);
    check("t3ov_lo", lo, 32'h8000_0000);
    check("t3ov_hi", hi, 32'd0);
    check("t3ov_dz", {31'd0, div_zero}, 32'd0);

    // 4. MTHI/MTLO then divide by zero
    @(negedge clock);
    wr_hi = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_5678;
    @(negedge clock);
    wr_lo = 1'b0;
    check("t4_wr_hi", hi, 32'h0000_1234);
    check("t4_wr_lo", lo, 32'h0000_5678);
    launch(OP_DIV, 32'd5, 32'd0);
    wait_done(0, k, gaps);
    check("t4_lat", k, 32'd1);
    check("t4_dz", {31'd0, div_zero}, 32'd1);
    check("t4_hi", hi, 32'h0000_1234);
    check("t4_lo", lo, 32'h0000_5678);
    @(negedge clock);
    check("t4_dz_pulse", {31'd0, div_zero}, 32'd0);

    // 5. start while busy ignored; start in done cycle ignored
    kre = EE ? 1 : 5;
    launch(OP_MULT, 32'd3, 32'd3);
    for (int i = 0; i < kre; i++) @(negedge clock);
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(kre + 1, k, gaps);
    check("t5_lat", k, mul_lat(32'd3));
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd9);
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("t5_done_cycle_start_busy", {31'd0, busy}, 32'd0);
    check("t5_done_cycle_start_done", {31'd0, done}, 32'd0);

    // 5b. reset mid-operation
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("t5r_busy", {31'd0, busy}, 32'd0);
    check("t5r_hi", hi, 32'd0);
    check("t5r_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done !== 1'b0) seen++;
    end
    check("t5r_no_done", seen, 32'd0);

    // 6. MTLO on the FIX edge loses to write-back
    lat = mul_lat(32'd2);
    launch(OP_MULTU, 32'd2, 32'd2);
    for (int i = 0; i < lat - 1; i++) @(negedge clock);
    wr_lo = 1'b1; wr_data = 32'h0000_AAAA;
    @(negedge clock);
    wr_lo = 1'b0;
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_lo", lo, 32'd4);
    check("t6_hi", hi, 32'd0);

    // 6b. latency with/without early exit
    launch(OP_MULTU, 32'd5, 32'd3);
    wait_done(0, k, gaps);
    check("t6b_lat", k, EE ? 32'd3 : 32'd33);
    check("t6b_lo", lo, 32'h0000_000F);
    check("t6b_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
